// File: rtl/prng_xoshiro128_jump_if.sv
`default_nettype none
// ============================================================================
// Module      : prng_xoshiro128_jump_if
// Description : Control, seed, state and result-stream bundle for the
//               xoshiro128 generator with jump engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface prng_xoshiro128_jump_if;
    logic        cg;
    logic        seed_valid;
    logic [31:0] seed_s0;
    logic [31:0] seed_s1;
    logic [31:0] seed_s2;
    logic [31:0] seed_s3;
    logic        jump;
    logic        long_jump;
    logic        busy;
    logic        seed_err;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
    logic        valid;
    logic        ready;
    logic [31:0] result;

    // Consumer / controller side
    modport master (
        output cg, seed_valid, seed_s0, seed_s1, seed_s2, seed_s3,
               jump, long_jump, ready,
        input  busy, seed_err, s0, s1, s2, s3, valid, result
    );

    // Generator side
    modport slave (
        input  cg, seed_valid, seed_s0, seed_s1, seed_s2, seed_s3,
               jump, long_jump, ready,
        output busy, seed_err, s0, s1, s2, s3, valid, result
    );
endinterface
`default_nettype wire

// File: rtl/prng_xoshiro128_jump.sv
`default_nettype none
// ============================================================================
// Module      : prng_xoshiro128_jump
// Description : xoshiro128 PRNG with selectable "++" / "**" scrambler, a
//               valid/ready result stream and a 128-cycle jump engine that
//               advances the state by 2^64 (jump) or 2^96 (long_jump) steps.
//               Optional feature macro: PRNG_XOSHIRO_LONGJUMP_EN enables
//               long_jump; without it the long_jump request is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module prng_xoshiro128_jump #(
    parameter int unsigned SCRAMBLER = 0,
    parameter logic [31:0] RST_S0    = 32'd1,
    parameter logic [31:0] RST_S1    = 32'd2,
    parameter logic [31:0] RST_S2    = 32'd3,
    parameter logic [31:0] RST_S3    = 32'd4
) (
    input  wire logic                    i_clk,
    input  wire logic                    i_rst,
    prng_xoshiro128_jump_if.slave        bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_JUMP = 1'b1
    } fsm_t;

    // Polynomials packed so that bit k is word k/32, bit k%32 (LSB-first).
    localparam logic [127:0] c_POLY_JUMP =
        {32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b};
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
    localparam logic [127:0] c_POLY_LONG =
        {32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e};
`endif

    fsm_t             r_fsm,  w_fsm_nx;
    logic [3:0][31:0] r_s,    w_s_nx;
    logic [3:0][31:0] r_acc,  w_acc_nx;
    logic [6:0]       r_cnt,  w_cnt_nx;
    logic             r_seed_err, w_seed_err_nx;
    logic [3:0][31:0] w_next;
    logic [3:0][31:0] w_seed;
    logic [3:0][31:0] w_acc_step;
    logic [127:0]     w_poly;
    logic             w_seed_zero;
    logic             w_seed_ok;
    logic             w_seed_bad;
    logic             w_long_req;

`ifdef PRNG_XOSHIRO_LONGJUMP_EN
    logic             r_long, w_long_nx;
    assign w_long_req = bus.long_jump;
    assign w_poly     = r_long ? c_POLY_LONG : c_POLY_JUMP;
`else
    wire w_unused_long_jump = bus.long_jump;
    assign w_long_req = 1'b0;
    assign w_poly     = c_POLY_JUMP;
`endif

    assign w_seed      = {bus.seed_s3, bus.seed_s2, bus.seed_s1, bus.seed_s0};
    assign w_seed_zero = (w_seed == '0);
    assign w_seed_ok   = bus.seed_valid & ~w_seed_zero;
    assign w_seed_bad  = bus.seed_valid &  w_seed_zero;

    // xoshiro128 next(): pure function of the current state registers
    always_comb begin
        logic [31:0] t, n0, n1, n2, n3;
        t  = r_s[1] << 9;
        n2 = r_s[2] ^ r_s[0];
        n3 = r_s[3] ^ r_s[1];
        n1 = r_s[1] ^ n2;
        n0 = r_s[0] ^ n3;
        n2 = n2 ^ t;
        n3 = {n3[20:0], n3[31:21]};
        w_next = {n3, n2, n1, n0};
    end

    // Accumulator after folding in the current state when the poly bit is set
    assign w_acc_step = w_poly[r_cnt] ? (r_acc ^ r_s) : r_acc;

    // Next-state logic: seed load > jump start > stream transfer; jump steps
    always_comb begin
        w_fsm_nx      = r_fsm;
        w_s_nx        = r_s;
        w_acc_nx      = r_acc;
        w_cnt_nx      = r_cnt;
        w_seed_err_nx = bus.cg & w_seed_bad;
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
        w_long_nx     = r_long;
`endif
        if (bus.cg) begin
            if (w_seed_ok) begin
                // A valid seed always wins and aborts any jump in flight.
                w_s_nx   = w_seed;
                w_fsm_nx = ST_IDLE;
                w_acc_nx = '0;
                w_cnt_nx = '0;
            end else begin
                case (r_fsm)
                    ST_IDLE: begin
                        // A rejected zero seed still blocks start and transfer.
                        if (!w_seed_bad) begin
                            if (w_long_req || bus.jump) begin
                                w_fsm_nx = ST_JUMP;
                                w_acc_nx = '0;
                                w_cnt_nx = '0;
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
                                w_long_nx = w_long_req;
`endif
                            end else if (bus.ready) begin
                                w_s_nx = w_next;
                            end
                        end
                    end
                    ST_JUMP: begin
                        // A zero seed is ignored here so the jump keeps its
                        // fixed 128-step length.
                        if (r_cnt == 7'd127) begin
                            w_s_nx   = w_acc_step;
                            w_acc_nx = '0;
                            w_cnt_nx = '0;
                            w_fsm_nx = ST_IDLE;
                        end else begin
                            w_s_nx   = w_next;
                            w_acc_nx = w_acc_step;
                            w_cnt_nx = r_cnt + 7'd1;
                        end
                    end
                    default: w_fsm_nx = ST_IDLE;
                endcase
            end
        end
    end

    // State, accumulator, counter and FSM registers with async reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_fsm      <= ST_IDLE;
            r_s        <= {RST_S3, RST_S2, RST_S1, RST_S0};
            r_acc      <= '0;
            r_cnt      <= '0;
            r_seed_err <= 1'b0;
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
            r_long     <= 1'b0;
`endif
        end else begin
            r_fsm      <= w_fsm_nx;
            r_s        <= w_s_nx;
            r_acc      <= w_acc_nx;
            r_cnt      <= w_cnt_nx;
            r_seed_err <= w_seed_err_nx;
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
            r_long     <= w_long_nx;
`endif
        end
    end

    generate
        if (SCRAMBLER == 1) begin : g_star_star
            // rotl(s1*5,7)*9 with shift-add multiplies, wrapping mod 2^32
            logic [31:0] w_mul5;
            logic [31:0] w_rot;
            assign w_mul5     = r_s[1] + (r_s[1] << 2);
            assign w_rot      = {w_mul5[24:0], w_mul5[31:25]};
            assign bus.result = w_rot + (w_rot << 3);
        end else begin : g_plus_plus
            // rotl(s0+s3,7)+s0
            logic [31:0] w_sum;
            assign w_sum      = r_s[0] + r_s[3];
            assign bus.result = {w_sum[24:0], w_sum[31:25]} + r_s[0];
        end
    endgenerate

    assign bus.busy     = (r_fsm == ST_JUMP);
    assign bus.valid    = (r_fsm == ST_IDLE) & bus.cg;
    assign bus.seed_err = r_seed_err;
    assign bus.s0       = r_s[0];
    assign bus.s1       = r_s[1];
    assign bus.s2       = r_s[2];
    assign bus.s3       = r_s[3];

endmodule
`default_nettype wire

// File: tb/tb_prng_xoshiro128_jump.sv
`timescale 1ns/1ps
module tb_prng_xoshiro128_jump;

    typedef logic [3:0][31:0] st_t;

    localparam logic [127:0] POLY_J =
        {32'h77f2db5b, 32'h6fa035c3, 32'hf542d2d3, 32'h8764000b};
    localparam logic [127:0] POLY_L =
        {32'h1c580662, 32'hccf5a0ef, 32'h0b6f099f, 32'hb523952e};

    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    st_t  m;

    always #5 clk = ~clk;

    prng_xoshiro128_jump_if bus0();
    prng_xoshiro128_jump_if bus1();

    // Second DUT ("**") sees identical stimulus.
    assign bus1.cg         = bus0.cg;
    assign bus1.seed_valid = bus0.seed_valid;
    assign bus1.seed_s0    = bus0.seed_s0;
    assign bus1.seed_s1    = bus0.seed_s1;
    assign bus1.seed_s2    = bus0.seed_s2;
    assign bus1.seed_s3    = bus0.seed_s3;
    assign bus1.jump       = bus0.jump;
    assign bus1.long_jump  = bus0.long_jump;
    assign bus1.ready      = bus0.ready;

    prng_xoshiro128_jump #(.SCRAMBLER(0)) dut_pp (.i_clk(clk), .i_rst(rst), .bus(bus0));
    prng_xoshiro128_jump #(.SCRAMBLER(1)) dut_ss (.i_clk(clk), .i_rst(rst), .bus(bus1));

    // ---------------- reference model (C-style xoshiro128) ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic st_t nxt(input st_t s);
        logic [31:0] t;
        t = s[1] << 9;
        s[2] ^= s[0];
        s[3] ^= s[1];
        s[1] ^= s[2];
        s[0] ^= s[3];
        s[2] ^= t;
        s[3] = rotl(s[3], 11);
        return s;
    endfunction

    function automatic logic [31:0] scr_pp(input st_t s);
        logic [31:0] a;
        a = s[0] + s[3];
        return rotl(a, 7) + s[0];
    endfunction

    function automatic logic [31:0] scr_ss(input st_t s);
        logic [31:0] a, b;
        a = s[1] * 32'd5;
        b = rotl(a, 7);
        return b * 32'd9;
    endfunction

    function automatic st_t jump_ref(input st_t s, input logic [127:0] poly);
        st_t acc;
        acc = '0;
        for (int w = 0; w < 4; w++)
            for (int b = 0; b < 32; b++) begin
                if (poly[w*32 + b]) acc ^= s;
                s = nxt(s);
            end
        return acc;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input st_t e);
        check({tag, ".s0"}, bus0.s0, e[0]);
        check({tag, ".s1"}, bus0.s1, e[1]);
        check({tag, ".s2"}, bus0.s2, e[2]);
        check({tag, ".s3"}, bus0.s3, e[3]);
        check({tag, ".res_pp"}, bus0.result, scr_pp(e));
        check({tag, ".res_ss"}, bus1.result, scr_ss(e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input st_t v);
        bus0.seed_s0    = v[0];
        bus0.seed_s1    = v[1];
        bus0.seed_s2    = v[2];
        bus0.seed_s3    = v[3];
        bus0.seed_valid = 1'b1;
        step();
        bus0.seed_valid = 1'b0;
    endtask

    function automatic st_t rand_state();
        st_t v;
        for (int i = 0; i < 4; i++) v[i] = $urandom;
        v[0] = v[0] | 32'd1;
        return v;
    endfunction

    task automatic do_jump(input string tag, input bit use_j, input bit use_l,
                           input int exp_cycles, input st_t exp_s);
        int cnt;
        int guard;
        bus0.jump      = use_j;
        bus0.long_jump = use_l;
        step();
        bus0.jump      = 1'b0;
        bus0.long_jump = 1'b0;
        cnt   = 0;
        guard = 0;
        while (bus0.busy && guard < 400) begin
            cnt++;
            if (cnt == 1) check({tag, ".valid_low"}, {31'd0, bus0.valid}, 32'd0);
            step();
            guard++;
        end
        check({tag, ".busy_cycles"}, 32'(cnt), 32'(exp_cycles));
        check_state({tag, ".final"}, exp_s);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        st_t s_seed;
        st_t s_new;
        st_t s_exp;
        int  en_cnt;
        int  guard;
        bit  g;
        bit  r;

        bus0.cg         = 1'b1;
        bus0.seed_valid = 1'b0;
        bus0.seed_s0    = '0;
        bus0.seed_s1    = '0;
        bus0.seed_s2    = '0;
        bus0.seed_s3    = '0;
        bus0.jump       = 1'b0;
        bus0.long_jump  = 1'b0;
        bus0.ready      = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m = {32'd4, 32'd3, 32'd2, 32'd1};
        check("rst.busy",     {31'd0, bus0.busy},     32'd0);
        check("rst.seed_err", {31'd0, bus0.seed_err}, 32'd0);
        check("rst.valid",    {31'd0, bus0.valid},    32'd1);
        check("rst.res_pp_641",   bus0.result, 32'd641);
        check("rst.res_ss_11520", bus1.result, 32'd11520);
        check_state("rst", m);

        // Hold with ready low
        repeat (10) step();
        check("hold.res_ss", bus1.result, 32'd11520);
        check_state("hold", m);

        // First transfer
        bus0.ready = 1'b1;
        step();
        bus0.ready = 1'b0;
        m = nxt(m);
        check("xfer1.s0", bus0.s0, 32'd7);
        check("xfer1.s1", bus0.s1, 32'd0);
        check("xfer1.s2", bus0.s2, 32'd1026);
        check("xfer1.s3", bus0.s3, 32'd12288);
        check("xfer1.res_pp", bus0.result, 32'd1573767);
        check_state("xfer1", m);

        // Random back-pressure stream
        for (int i = 0; i < 40; i++) begin
            r = 1'($urandom_range(0, 1));
            bus0.ready = r;
            step();
            if (r) m = nxt(m);
            check_state("stream", m);
        end
        bus0.ready = 1'b0;

        // jump() from seed (1,2,3,4), then 1000 results
        m = {32'd4, 32'd3, 32'd2, 32'd1};
        load_seed(m);
        check_state("seed1234", m);
        s_exp = jump_ref(m, POLY_J);
        do_jump("jump", 1'b1, 1'b0, 128, s_exp);
        m = s_exp;
        bus0.ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            check("post_jump.res_pp", bus0.result, scr_pp(m));
            check("post_jump.res_ss", bus1.result, scr_ss(m));
            step();
            m = nxt(m);
        end
        bus0.ready = 1'b0;
        check_state("post_jump", m);

        // long_jump(), and both requests together
`ifdef PRNG_XOSHIRO_LONGJUMP_EN
        s_exp = jump_ref(m, POLY_L);
        do_jump("long", 1'b0, 1'b1, 128, s_exp);
        m = s_exp;
        s_exp = jump_ref(m, POLY_L);
        do_jump("both", 1'b1, 1'b1, 128, s_exp);
        m = s_exp;
`else
        do_jump("long_ignored", 1'b0, 1'b1, 0, m);
        s_exp = jump_ref(m, POLY_J);
        do_jump("both", 1'b1, 1'b1, 128, s_exp);
        m = s_exp;
`endif

        // Random seed then jump
        m = rand_state();
        load_seed(m);
        check_state("rseed", m);
        s_exp = jump_ref(m, POLY_J);
        do_jump("rjump", 1'b1, 1'b0, 128, s_exp);
        m = s_exp;

        // All-zero seed together with jump and ready
        bus0.seed_s0 = '0; bus0.seed_s1 = '0; bus0.seed_s2 = '0; bus0.seed_s3 = '0;
        bus0.seed_valid = 1'b1;
        bus0.jump       = 1'b1;
        bus0.ready      = 1'b1;
        step();
        bus0.seed_valid = 1'b0;
        bus0.jump       = 1'b0;
        bus0.ready      = 1'b0;
        check("zseed.err",  {31'd0, bus0.seed_err}, 32'd1);
        check("zseed.busy", {31'd0, bus0.busy},     32'd0);
        check_state("zseed", m);
        step();
        check("zseed.err_clr", {31'd0, bus0.seed_err}, 32'd0);
        check("zseed.busy2",   {31'd0, bus0.busy},     32'd0);
        check_state("zseed2", m);

        // Seed abort mid-jump
        m = rand_state();
        load_seed(m);
        bus0.jump = 1'b1;
        step();
        bus0.jump = 1'b0;
        repeat (59) step();
        check("abort.busy_before", {31'd0, bus0.busy}, 32'd1);
        s_new = rand_state();
        load_seed(s_new);
        m = s_new;
        check("abort.busy_after", {31'd0, bus0.busy},  32'd0);
        check("abort.valid",      {31'd0, bus0.valid}, 32'd1);
        check_state("abort", m);

        // Async reset at cycle 90 of a jump
        bus0.jump = 1'b1;
        step();
        bus0.jump = 1'b0;
        repeat (89) step();
        check("rstmid.busy_before", {31'd0, bus0.busy}, 32'd1);
        rst = 1'b1;
        #1;
        m = {32'd4, 32'd3, 32'd2, 32'd1};
        check("rstmid.busy", {31'd0, bus0.busy}, 32'd0);
        check_state("rstmid", m);
        step();
        rst = 1'b0;
        step();
        check("rstmid.busy2", {31'd0, bus0.busy}, 32'd0);
        check_state("rstmid2", m);

        // Clock-gate gap of 20 cycles during a jump
        s_seed = rand_state();
        load_seed(s_seed);
        s_exp = jump_ref(s_seed, POLY_J);
        bus0.jump = 1'b1;
        step();
        bus0.jump = 1'b0;
        en_cnt = bus0.busy ? 1 : 0;
        guard  = 0;
        while (bus0.busy && guard < 400) begin
            g = !(guard >= 30 && guard < 50);
            bus0.cg = g;
            if (guard == 40) begin
                check("cg.valid_low", {31'd0, bus0.valid}, 32'd0);
                check("cg.busy_held", {31'd0, bus0.busy},  32'd1);
            end
            step();
            if (bus0.busy && g) en_cnt++;
            guard++;
        end
        bus0.cg = 1'b1;
        check("cg.enabled_busy", 32'(en_cnt), 32'd128);
        m = s_exp;
        check_state("cg.final", m);

        // Clock gate low in IDLE: requests dropped, no transfers
        bus0.cg    = 1'b0;
        bus0.ready = 1'b1;
        bus0.jump  = 1'b1;
        repeat (5) step();
        check("cgidle.valid", {31'd0, bus0.valid}, 32'd0);
        check("cgidle.busy",  {31'd0, bus0.busy},  32'd0);
        check_state("cgidle", m);
        bus0.jump  = 1'b0;
        bus0.ready = 1'b0;
        bus0.cg    = 1'b1;
        #0;
        check("cgidle.valid_back", {31'd0, bus0.valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
